cdc_pulse_req_tx: RTL

- Source-side endpoint of a closed-loop 4-phase req/ack pulse-crossing link.
- Accepts single-cycle event strobes in the CLK domain and queues them in a pending counter, so events arriving while a handshake is in flight are not lost.
- Each queued event is issued as one full REQ_OUT/ACK_IN 4-phase handshake toward a far-domain receiver. The receiver edge-detects REQ and returns its synchronized level on ACK.
- Sits in front of any module that must deliver counted triggers or commands across a clock boundary.

---
 rtl/cdc_level_sync.sv | 34 +++
 rtl/cdc_pulse_req_tx.sv | 104 ++++++++++
 2 files changed

// File: rtl/cdc_level_sync.sv
// Multi-flop level synchronizer with asynchronous active-high reset to 0.
// Shared between the request transmitter and its matching receiver.
module cdc_level_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES:0] chain;

    assign chain[0] = d;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic stage_reg;

            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= chain[gi];
                end
            end

            assign chain[gi+1] = stage_reg;
        end
    endgenerate

    assign q = chain[STAGES];

endmodule

// File: rtl/cdc_pulse_req_tx.sv
// Source side of a 4-phase req/ack pulse crossing: counts local strobes and
// issues one full REQ/ACK handshake per queued event.
module cdc_pulse_req_tx #(
    parameter int CNT_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 pulse_in,
    input  logic                 ack_in,
    input  logic                 clr_overflow,
    output logic                 req_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ_HI = 2'd1;
    localparam logic [1:0] ST_REQ_LO = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic                 req_reg;
    logic                 req_next;
    logic [CNT_WIDTH-1:0] pending_reg;
    logic [CNT_WIDTH-1:0] pending_next;
    logic                 overflow_reg;
    logic                 overflow_next;
    logic                 ack_s;
    logic                 launch;
    logic                 drop;

    cdc_level_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (ack_in),
        .q      (ack_s)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            req_reg      <= 1'b0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
        end
    end

    // A launch also waits for ack_s=0 so a stale ack left over from a reset
    // mid-handshake is never taken as the answer to a new request.
    always_comb begin
        state_next = ST_IDLE;
        launch     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if ((pending_reg != '0) && !ack_s) begin
                    state_next = ST_REQ_HI;
                    launch     = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_REQ_HI: state_next = ack_s ? ST_REQ_LO : ST_REQ_HI;
            ST_REQ_LO: state_next = ack_s ? ST_REQ_LO : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_next      = (state_next == ST_REQ_HI);
        drop          = pulse_in && !launch && (pending_reg == CNT_MAX);
        pending_next  = pending_reg;
        overflow_next = overflow_reg;

        if (pulse_in && !launch && !drop) begin
            pending_next = pending_reg + 1'b1;
        end else if (!pulse_in && launch) begin
            pending_next = pending_reg - 1'b1;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_overflow) begin
            overflow_next = 1'b0;
        end
    end

    assign req_out  = req_reg;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != ST_IDLE) || (pending_reg != '0);

endmodule
